// File: rtl/char_plot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : char_plot_sequencer
// Description : Plays the received character buffer back to the glyph
//               plotter. Waits for end-of-file, latches the buffer fill count,
//               walks the read select from 0 to n-1 and hands one glyph per
//               character to the plotter over a valid/ready handshake. It
//               tracks the text cursor, auto-wraps long lines and turns
//               newline codes into cursor moves.
// Ports       : clock        - system clock, rising edge
//               resetn       - asynchronous active-low reset
//               char_ready   - raw receive strobe (synchronised internally)
//               eof          - raw end-of-file level (synchronised internally)
//               char_count   - buffer write index (characters stored)
//               curr_char    - buffer read data at select
//               select       - buffer read index
//               glyph_code   - character to plot
//               glyph_col    - cursor column for glyph_code
//               glyph_row    - cursor row for glyph_code
//               glyph_valid  - glyph fields valid
//               glyph_ready  - plotter accepts the glyph
//               busy         - playback in progress
//               done         - playback finished
//               overflow     - sticky buffer or page overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module char_plot_sequencer #(
  parameter int          DEPTH      = 100,
  parameter int          LINE_CHARS = 16,
  parameter int          MAX_ROWS   = 10,
  parameter logic [5:0]  NL_CODE    = 6'h3F
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       char_ready,
  input  logic       eof,
  input  logic [6:0] char_count,
  input  logic [5:0] curr_char,
  output logic [6:0] select,
  output logic [5:0] glyph_code,
  output logic [4:0] glyph_col,
  output logic [3:0] glyph_row,
  output logic       glyph_valid,
  input  logic       glyph_ready,
  output logic       busy,
  output logic       done,
  output logic       overflow
);

  localparam logic [6:0] DEPTH_C  = 7'(DEPTH);
  localparam logic [4:0] LAST_COL = 5'(LINE_CHARS - 1);
  localparam logic [3:0] LAST_ROW = 4'(MAX_ROWS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_NEWLINE = 3'd3;
  localparam logic [2:0] S_ADVANCE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0] state;
  logic [2:0] state_next;

  // Two synchroniser flops plus one history flop for edge detection
  logic cr_s1, cr_s2, cr_s3;
  logic eof_s1, eof_s2, eof_s3;
  logic char_edge;
  logic eof_rise;

  logic [6:0] n_chars;
  logic [6:0] n_clamped;
  logic       at_last_col;
  logic       at_last_row;
  logic       issue_xfer;
  logic       page_full;

  assign char_edge   = cr_s2 & ~cr_s3;
  assign eof_rise    = eof_s2 & ~eof_s3;
  assign n_clamped   = (char_count > DEPTH_C) ? DEPTH_C : char_count;
  assign at_last_col = (glyph_col == LAST_COL);
  assign at_last_row = (glyph_row == LAST_ROW);
  assign issue_xfer  = (state == S_ISSUE) && glyph_ready;
  // A wrap or newline on the last row has nowhere to go: the page is full
  assign page_full   = (issue_xfer && at_last_col && at_last_row) ||
                       ((state == S_NEWLINE) && at_last_row);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cr_s1  <= 1'b0;
      cr_s2  <= 1'b0;
      cr_s3  <= 1'b0;
      eof_s1 <= 1'b0;
      eof_s2 <= 1'b0;
      eof_s3 <= 1'b0;
    end else begin
      cr_s1  <= char_ready;
      cr_s2  <= cr_s1;
      cr_s3  <= cr_s2;
      eof_s1 <= eof;
      eof_s2 <= eof_s1;
      eof_s3 <= eof_s2;
    end
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (eof_rise) begin
          state_next = (n_clamped == 7'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        state_next = (curr_char == NL_CODE) ? S_NEWLINE : S_ISSUE;
      end
      S_ISSUE: begin
        if (glyph_ready) begin
          state_next = page_full ? S_DONE : S_ADVANCE;
        end
      end
      S_NEWLINE: begin
        state_next = page_full ? S_DONE : S_ADVANCE;
      end
      S_ADVANCE: begin
        state_next = (select == n_chars - 7'd1) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        if (!eof_s2) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    glyph_valid = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      S_FETCH, S_NEWLINE, S_ADVANCE: busy = 1'b1;
      S_ISSUE: begin
        busy        = 1'b1;
        glyph_valid = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: fill count, read select, glyph latch and text cursor
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      n_chars    <= 7'd0;
      select     <= 7'd0;
      glyph_code <= 6'd0;
      glyph_col  <= 5'd0;
      glyph_row  <= 4'd0;
      overflow   <= 1'b0;
    end else begin
      if ((char_edge && (char_count >= DEPTH_C)) || page_full) begin
        overflow <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (eof_rise) begin
            n_chars   <= n_clamped;
            select    <= 7'd0;
            glyph_col <= 5'd0;
            glyph_row <= 4'd0;
          end
        end
        S_FETCH: begin
          glyph_code <= curr_char;
        end
        S_ISSUE: begin
          if (glyph_ready) begin
            if (!at_last_col) begin
              glyph_col <= glyph_col + 5'd1;
            end else if (!at_last_row) begin
              glyph_col <= 5'd0;
              glyph_row <= glyph_row + 4'd1;
            end
          end
        end
        S_NEWLINE: begin
          if (!at_last_row) begin
            glyph_col <= 5'd0;
            glyph_row <= glyph_row + 4'd1;
          end
        end
        S_ADVANCE: begin
          if (select != n_chars - 7'd1) begin
            select <= select + 7'd1;
          end
        end
        S_DONE: begin
          if (!eof_s2) begin
            select    <= 7'd0;
            glyph_col <= 5'd0;
            glyph_row <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
